// File: rtl/boot_rom_pkg.sv
// Shared constants, state encoding and response record for the boot ROM bridge.
package boot_rom_pkg;

  localparam logic [63:0] BOOT_ROM_BASE  = 64'h1000;
  localparam int unsigned BOOT_ROM_BYTES = 32;
  // Width of the ID field carried in the response record; ID_WIDTH must not exceed it.
  localparam int unsigned BOOT_ROM_ID_W  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWresp = 2'd2
  } state_e;

  typedef struct packed {
    logic [63:0]              data;
    logic                     err;
    logic                     last;
    logic [BOOT_ROM_ID_W-1:0] id;
  } rom_rsp_t;

endpackage

// File: rtl/boot_rom_bridge.sv
// Request/response front-end for the combinational 64-bit boot ROM: single or INCR burst
// reads with registered beats, backpressure and ID echo; writes and misses return errors.
module boot_rom_bridge
  import boot_rom_pkg::*;
#(
  parameter int unsigned ID_WIDTH  = BOOT_ROM_ID_W,
  parameter logic [63:0] ROM_BASE  = BOOT_ROM_BASE,
  parameter int unsigned ROM_BYTES = BOOT_ROM_BYTES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [63:0]         req_addr_i,
  input  logic                req_we_i,
  input  logic [7:0]          req_len_i,
  input  logic [ID_WIDTH-1:0] req_id_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [63:0]         rsp_data_o,
  output logic                rsp_err_o,
  output logic                rsp_last_o,
  output logic [ID_WIDTH-1:0] rsp_id_o,
  output logic [63:0]         rom_addr_o,
  input  logic [63:0]         rom_data_i
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  len_q, len_d;
  logic [63:0] addr_q, addr_d;
  logic        wrap_q, wrap_d;
  rom_rsp_t    rsp_q, rsp_d;

  logic [64:0] addr_next;
  logic [63:0] req_base;
  logic        rsp_hs;
  logic        beat_ok;

  function automatic logic in_window(input logic [63:0] a);
    logic [64:0] lim;
    lim = {1'b0, ROM_BASE} + 65'(ROM_BYTES);
    return (a >= ROM_BASE) && ({1'b0, a} < lim);
  endfunction

  // Carry out of bit 63 marks a wrapped address, which is never inside the window.
  assign addr_next  = {1'b0, addr_q} + 65'd8;
  assign req_base   = req_addr_i & ~64'h7;
  assign rom_addr_o = (state_q == StIdle) ? req_base : addr_next[63:0];
  assign rsp_hs     = rsp_valid_o && rsp_ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wrap_d  = wrap_q;
    rsp_d   = rsp_q;
    beat_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          len_d    = req_len_i;
          addr_d   = req_base;
          cnt_d    = 8'd0;
          wrap_d   = 1'b0;
          rsp_d.id = BOOT_ROM_ID_W'(req_id_i);
          if (req_we_i) begin
            rsp_d.data = 64'd0;
            rsp_d.err  = 1'b1;
            rsp_d.last = 1'b1;
            state_d    = StWresp;
          end else begin
            beat_ok    = in_window(req_base);
            rsp_d.data = beat_ok ? rom_data_i : 64'd0;
            rsp_d.err  = !beat_ok;
            rsp_d.last = (req_len_i == 8'd0);
            state_d    = StRead;
          end
        end
      end
      StRead: begin
        if (rsp_hs) begin
          if (cnt_q == len_q) begin
            state_d = StIdle;
          end else begin
            cnt_d      = cnt_q + 8'd1;
            addr_d     = addr_next[63:0];
            wrap_d     = wrap_q | addr_next[64];
            beat_ok    = in_window(addr_next[63:0]) && !wrap_d;
            rsp_d.data = beat_ok ? rom_data_i : 64'd0;
            rsp_d.err  = !beat_ok;
            rsp_d.last = (cnt_d == len_q);
          end
        end
      end
      StWresp: begin
        if (rsp_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      len_q   <= 8'd0;
      addr_q  <= 64'd0;
      wrap_q  <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wrap_q  <= wrap_d;
      rsp_q   <= rsp_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q != StIdle);
  assign rsp_data_o  = rsp_q.data;
  assign rsp_err_o   = rsp_q.err;
  assign rsp_last_o  = rsp_q.last;
  assign rsp_id_o    = ID_WIDTH'(rsp_q.id);

endmodule

// File: tb/tb_boot_rom_bridge.sv
// Scoreboard bench for boot_rom_bridge with a behavioural ROM and transaction model.
module tb_boot_rom_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_addr_i = 64'd0;
  logic        req_we_i = 1'b0;
  logic [7:0]  req_len_i = 8'd0;
  logic [3:0]  req_id_i = 4'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [63:0] rsp_data_o;
  logic        rsp_err_o;
  logic        rsp_last_o;
  logic [3:0]  rsp_id_o;
  logic [63:0] rom_addr_o;
  logic [63:0] rom_data_i;

  boot_rom_bridge #(
    .ID_WIDTH (4),
    .ROM_BASE (64'h1000),
    .ROM_BYTES(32)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_we_i   (req_we_i),
    .req_len_i  (req_len_i),
    .req_id_i   (req_id_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .rsp_last_o (rsp_last_o),
    .rsp_id_o   (rsp_id_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i)
  );

  always #5 clk_i = ~clk_i;

  logic [63:0] rom_words [4];
  initial begin
    rom_words[0] = 64'h02028593_00000297;
    rom_words[1] = 64'h0182b283_f1402573;
    rom_words[2] = 64'h00000000_00028067;
    rom_words[3] = 64'h00000000_80000000;
  end

  // Outside the window the ROM returns junk so a missing data mask is visible.
  always_comb begin
    rom_data_i = rom_addr_o ^ 64'hDEAD_BEEF_0000_0000;
    if (rom_addr_o >= 64'h1000 && rom_addr_o < 64'h1020) rom_data_i = rom_words[rom_addr_o[4:3]];
  end

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic        last;
    logic [3:0]  id;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   ready_mode = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expect(input logic [63:0] addr, input logic we, input logic [7:0] len,
                             input logic [3:0] id);
    exp_t e;
    if (we) begin
      e.data = 64'd0; e.err = 1'b1; e.last = 1'b1; e.id = id;
      sb_q.push_back(e);
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        logic [64:0] full;
        logic [63:0] a;
        bit          ok;
        full = {1'b0, addr & ~64'h7} + 65'(i) * 65'd8;
        a    = full[63:0];
        ok   = !full[64] && a >= 64'h1000 && a < 64'h1020;
        e.data = ok ? rom_words[int'((a - 64'h1000) >> 3)] : 64'd0;
        e.err  = !ok;
        e.last = (i == int'(len));
        e.id   = id;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [63:0] addr, input logic we, input logic [7:0] len,
                      input logic [3:0] id);
    int budget;
    push_expect(addr, we, len, id);
    @(negedge clk_i);
    req_addr_i  = addr;
    req_we_i    = we;
    req_len_i   = len;
    req_id_i    = id;
    req_valid_i = 1'b1;
    budget = 0;
    while (!req_ready_o && budget < 400) begin
      @(negedge clk_i);
      budget++;
    end
    if (!req_ready_o) begin
      chk("req_accept_timeout", 64'(req_ready_o), 64'd1);
      req_valid_i = 1'b0;
      sb_q.delete();
      return;
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rsp_valid_latency", 64'(rsp_valid_o), 64'd1);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (!(sb_q.size() == 0 && req_ready_o) && budget < 600) begin
      @(negedge clk_i);
      budget++;
    end
    if (!(sb_q.size() == 0 && req_ready_o)) begin
      chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #1 rsp_ready_i = ready_mode ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard pops on handshake plus protocol checks between consecutive cycles.
  bit          prev_stall = 0;
  bit          prev_more = 0;
  bit          chk_rdy_next = 0;
  logic [63:0] snap_data;
  logic        snap_err, snap_last;
  logic [3:0]  snap_id;

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      prev_stall   = 0;
      prev_more    = 0;
      chk_rdy_next = 0;
    end else begin
      if (chk_rdy_next) chk("req_ready_after_last", 64'(req_ready_o), 64'd1);
      if (prev_stall || prev_more) chk("rsp_valid_held", 64'(rsp_valid_o), 64'd1);
      if (prev_stall) begin
        chk("stall_data", rsp_data_o, snap_data);
        chk("stall_err", 64'(rsp_err_o), 64'(snap_err));
        chk("stall_last", 64'(rsp_last_o), 64'(snap_last));
        chk("stall_id", 64'(rsp_id_o), 64'(snap_id));
      end
      if (rsp_valid_o) chk("req_ready_busy", 64'(req_ready_o), 64'd0);
      prev_stall   = rsp_valid_o && !rsp_ready_i;
      prev_more    = rsp_valid_o && rsp_ready_i && !rsp_last_o;
      chk_rdy_next = rsp_valid_o && rsp_ready_i && rsp_last_o;
      snap_data = rsp_data_o;
      snap_err  = rsp_err_o;
      snap_last = rsp_last_o;
      snap_id   = rsp_id_o;
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 64'(rsp_valid_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("beat_data", rsp_data_o, e.data);
          chk("beat_err", 64'(rsp_err_o), 64'(e.err));
          chk("beat_last", 64'(rsp_last_o), 64'(e.last));
          chk("beat_id", 64'(rsp_id_o), 64'(e.id));
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_data", rsp_data_o, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err_o), 64'd0);
    chk("rst_rsp_last", 64'(rsp_last_o), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id_o), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk_reset_outputs();
    rst_i = 1'b0;
    #1 chk_reset_outputs();

    ready_mode = 1'b1;
    send(64'h1000, 1'b0, 8'd0, 4'd3);
    wait_idle();
    send(64'h1000, 1'b0, 8'd3, 4'd7);
    wait_idle();
    ready_mode = 1'b0;
    send(64'h1000, 1'b0, 8'd3, 4'd8);
    wait_idle();
    ready_mode = 1'b1;
    send(64'h1018, 1'b0, 8'd1, 4'd2);
    wait_idle();
    send(64'h1000, 1'b1, 8'd9, 4'd5);
    send(64'h1004, 1'b0, 8'd0, 4'd6);
    wait_idle();

    // Reset while the second beat of a 4-beat burst is on the bus.
    send(64'h1000, 1'b0, 8'd3, 4'd9);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1 chk("rst_async_valid_drop", 64'(rsp_valid_o), 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk_reset_outputs();
    repeat (3) begin
      @(negedge clk_i);
      chk("no_replay_after_rst", 64'(rsp_valid_o), 64'd0);
    end
    send(64'h1008, 1'b0, 8'd0, 4'd1);
    wait_idle();

    for (int t = 0; t < 40; t++) begin
      logic [63:0] addr;
      if ($urandom_range(0, 9) == 0) addr = 64'hFFFF_FFFF_FFFF_FFE8 + 64'($urandom_range(0, 7));
      else addr = 64'h0FF0 + 64'($urandom_range(0, 55));
      ready_mode = 1'($urandom_range(0, 1));
      send(addr, 1'($urandom_range(0, 4) == 0), 8'($urandom_range(0, 5)),
           4'($urandom_range(0, 15)));
    end
    wait_idle();
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares",
             n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
